conv1_sched: RTL and testbench
==============================

Name: conv1_sched

Overview:
- Sequencer for the conv1 25-tap PE in the LeNet-5 accelerator.
- Per output channel, it loads the 25 PE weights from weight memory, then streams all 28x28 window positions to the ifmap window buffer.
- It tracks the combined window-buffer and PE latency and issues the ofmap write address/enable when each PE result is valid.
- It also drives the PE relu_en/quan_en controls from per-run configuration.

Parameters:
- IMG_W, 32, input feature-map width/height.
- K, 5, kernel size; the PE has K*K = 25 taps.
- OUT_CH, 6, number of output channels.
- MEM_LAT, 1, weight-memory read latency in cycles (must be at least 1).
- IF_LAT, 1, cycles from win_valid until the 25 pixels are present at the PE inputs.
- PE_LAT, 2, PE latency: multiply register plus sum register.

Derived: OUT_W = IMG_W-K+1 = 28; NPIX = OUT_W*OUT_W = 784; PIPE = IF_LAT+PE_LAT = 3.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- cfg_relu  in  1  ReLU enable, latched at start accept.
- cfg_quan  in  1  quantize enable, latched at start accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output write.
- ch_idx  out  3  current output channel.
- w_rd_en  out  1  weight-memory read strobe.
- w_rd_addr  out  8  weight-memory address = ch_idx*25 + k.
- w_ld_en  out  1  PE weight-register load strobe.
- w_ld_idx  out  5  PE weight register to load (0..24).
- win_valid  out  1  window request to the ifmap buffer.
- win_row  out  5  window origin row (0..27).
- win_col  out  5  window origin column (0..27).
- relu_en  out  1  to PE; equals the latched cfg_relu.
- quan_en  out  1  to PE; equals the latched cfg_quan.
- ofm_wr_en  out  1  ofmap write strobe; PE output is valid this cycle.
- ofm_wr_addr  out  13  ofmap address = ch*784 + row*28 + col.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0.
  - Reset mid-run aborts immediately.
  - No done pulse is produced for the aborted run.
  - The latency pipeline is cleared, so no ofm_wr_en is asserted after reset.
- FSM states: IDLE, WLOAD, WWAIT, RUN, DRAIN, DONE.
- IDLE:
  - If start=1, latch cfg_relu/cfg_quan, set ch=0, go to WLOAD.
  - Otherwise stay in IDLE.
- WLOAD: 25 cycles, k=0..24.
  - w_rd_en=1 and w_rd_addr=ch*25+k each cycle.
  - Go to WWAIT after k=24.
- Weight load path:
  - A read issued in cycle c produces w_ld_en=1 with w_ld_idx=k in cycle c+MEM_LAT.
  - This uses a MEM_LAT-deep delay line for the {strobe, idx} pair.
- WWAIT: MEM_LAT cycles, so the last weight load lands before the first window. Then go to RUN.
- RUN: 784 cycles, one window per cycle with no gaps.
  - win_valid=1.
  - (row, col) is raster order: col increments first, wraps 27->0 and row increments.
  - Go to DRAIN after (27,27).
- Output tracking:
  - win_valid, row, col and ch are delayed PIPE cycles through a valid-tagged shift register.
  - ofm_wr_en is the delayed valid; ofm_wr_addr is built from the delayed fields.
  - This gives exactly 784 writes per channel, addresses ch*784 .. ch*784+783, strictly increasing.
- DRAIN: PIPE cycles, so weights are not overwritten while windows are in flight.
  - After DRAIN: if ch < OUT_CH-1, increment ch and go to WLOAD; otherwise go to DONE.
- DONE: one cycle, done=1, then go to IDLE.
- Timing: per channel 25+MEM_LAT+784+PIPE = 813 cycles with default parameters.
  - Start accepted in cycle 0.
  - First w_rd_en in cycle 1; first win_valid in cycle 27; first ofm_wr_en in cycle 30 (addr 0).
  - done in cycle 1+6*813 = 4879.
- start while busy is ignored; there is no queued request.
- start held high across DONE starts a new run on the IDLE cycle after DONE.
- relu_en/quan_en are stable for the entire run.
- Arithmetic widths:
  - ofm_wr_addr maximum 4703, fits 13 bits.
  - w_rd_addr maximum 149, fits 8 bits.
  - All counters are unsigned and use exact terminal-count compares, no wrap beyond terminal values.

Decomposition:
- Shared package lenet_pkg holds:
  - FSM state enum.
  - IMG_W/K/OUT_CH defaults.
  - Derived OUT_W and NPIX.
  - Address widths.
- Sub-module lat_pipe: parameterised DEPTH/WIDTH valid-tagged delay line with async reset.
  - Instanced once for the weight-load path (DEPTH=MEM_LAT).
  - Instanced once for the output-tag path (DEPTH=PIPE).

Test Plan:
- Single run, default parameters, start pulse in cycle 0:
  - w_rd_en in cycles 1-25 with addr 0..24.
  - w_ld_en in cycles 2-26 with idx 0..24.
  - win_valid in cycles 27-810.
  - ofm_wr_en in cycles 30-813 with addr 0..783.
  - done only in cycle 4879.
- Full scoreboard over the whole run: 4704 writes, addresses 0..4703 each exactly once and in order; w_rd_addr covers 0..149; no w_ld_en while any win_valid is in flight.
- cfg_relu=1, cfg_quan=0 at start, then toggle both inputs mid-run: relu_en=1 and quan_en=0 throughout the run; both 0 again after reset.
- start pulsed in cycles 100 and 2000 and held high through DONE: no disturbance mid-run; second run begins with w_rd_en on the cycle after IDLE is re-entered.
- rst asserted in cycle 500 (RUN, ch0), then released: all outputs 0 immediately; no ofm_wr_en afterwards; a fresh start replays from addr 0.
- MEM_LAT=2, IF_LAT=2 build: WWAIT lasts 2 cycles, first ofm_wr_en 4 cycles after first win_valid, per-channel period 815, done in cycle 4891.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet-5 conv1 sequencer: default geometry,
// address widths and the scheduler state encoding.
package lenet_pkg;

  localparam int DEF_IMG_W  = 32;
  localparam int DEF_K      = 5;
  localparam int DEF_OUT_CH = 6;
  localparam int DEF_OUT_W  = DEF_IMG_W - DEF_K + 1;
  localparam int DEF_NPIX   = DEF_OUT_W * DEF_OUT_W;

  localparam int W_ADDR_W   = 8;
  localparam int OFM_ADDR_W = 13;
  localparam int CH_W       = 3;
  localparam int POS_W      = 5;
  localparam int TAP_W      = 5;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_WWAIT = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/conv1_sched_if.sv
// Control/status bundle of the conv1 sequencer. All strobes (w_rd_en, w_ld_en,
// win_valid, ofm_wr_en) are single-cycle qualifiers with no ready/backpressure:
// the consumer must accept the accompanying fields in the cycle the strobe is high.
interface conv1_sched_if;
  import lenet_pkg::*;

  logic                  start;
  logic                  cfg_relu;
  logic                  cfg_quan;
  logic                  busy;
  logic                  done;
  logic [CH_W-1:0]       ch_idx;
  logic                  w_rd_en;
  logic [W_ADDR_W-1:0]   w_rd_addr;
  logic                  w_ld_en;
  logic [TAP_W-1:0]      w_ld_idx;
  logic                  win_valid;
  logic [POS_W-1:0]      win_row;
  logic [POS_W-1:0]      win_col;
  logic                  relu_en;
  logic                  quan_en;
  logic                  ofm_wr_en;
  logic [OFM_ADDR_W-1:0] ofm_wr_addr;
  state_t                state;

  modport master (
    input  start, cfg_relu, cfg_quan,
    output busy, done, ch_idx, w_rd_en, w_rd_addr, w_ld_en, w_ld_idx,
           win_valid, win_row, win_col, relu_en, quan_en,
           ofm_wr_en, ofm_wr_addr, state
  );

  modport slave (
    output start, cfg_relu, cfg_quan,
    input  busy, done, ch_idx, w_rd_en, w_rd_addr, w_ld_en, w_ld_idx,
           win_valid, win_row, win_col, relu_en, quan_en,
           ofm_wr_en, ofm_wr_addr, state
  );

endinterface

// File: rtl/conv1_sched_lat_pipe.sv
// Valid-tagged fixed-latency delay line. Data of invalid slots is forced to
// zero so idle outputs read as 0.
module lat_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             v_q [DEPTH];
  logic [WIDTH-1:0] d_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      v_q[0] <= in_valid;
      d_q[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: rtl/conv1_sched.sv
// conv1 sequencer: per output channel load 25 PE weights, stream every window
// position, and emit ofmap writes aligned to the window-buffer + PE latency.
module conv1_sched
  import lenet_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int K       = DEF_K,
  parameter int OUT_CH  = DEF_OUT_CH,
  parameter int MEM_LAT = 1,   // must be >= 1
  parameter int IF_LAT  = 1,
  parameter int PE_LAT  = 2
) (
  input  logic          clk,
  input  logic          rst,
  conv1_sched_if.master bus
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int NPIX  = OUT_W * OUT_W;
  localparam int TAPS  = K * K;
  localparam int PIPE  = IF_LAT + PE_LAT;
  localparam int TAG_W = CH_W + 2 * POS_W;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q;
  logic [TAP_W-1:0]   k_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [POS_W-1:0]   row_q, col_q;
  logic               relu_q, quan_q;

  logic k_last, wait_last, drain_last, col_last, row_last, ch_last;

  assign k_last     = (k_q == TAP_W'(TAPS - 1));
  assign wait_last  = (cnt_q == CNT_W'(MEM_LAT - 1));
  assign drain_last = (cnt_q == CNT_W'(PIPE - 1));
  assign col_last   = (col_q == POS_W'(OUT_W - 1));
  assign row_last   = (row_q == POS_W'(OUT_W - 1));
  assign ch_last    = (ch_q == CH_W'(OUT_CH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      relu_q  <= 1'b0;
      quan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            relu_q <= bus.cfg_relu;
            quan_q <= bus.cfg_quan;
            ch_q   <= '0;
          end
        end
        S_WLOAD: k_q <= k_last ? '0 : k_q + 1'b1;
        S_WWAIT: cnt_q <= wait_last ? '0 : cnt_q + 1'b1;
        S_RUN: begin
          if (col_last) begin
            col_q <= '0;
            row_q <= row_last ? '0 : row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_last) begin
            cnt_q <= '0;
            if (!ch_last) ch_q <= ch_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: ch_q <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_WLOAD;
      S_WLOAD: if (k_last) state_d = S_WWAIT;
      S_WWAIT: if (wait_last) state_d = S_RUN;
      S_RUN:   if (row_last && col_last) state_d = S_DRAIN;
      // Draining keeps the weights stable until the last window's result is out.
      S_DRAIN: if (drain_last) state_d = ch_last ? S_DONE : S_WLOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic                 rd_en;
  logic                 run_en;
  logic                 tag_valid;
  logic [TAG_W-1:0]     tag_data;
  logic [CH_W-1:0]      tag_ch;
  logic [POS_W-1:0]     tag_row, tag_col;

  assign rd_en  = (state_q == S_WLOAD);
  assign run_en = (state_q == S_RUN);

  lat_pipe #(.DEPTH(MEM_LAT), .WIDTH(TAP_W)) u_wld_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_data   (k_q),
    .out_valid (bus.w_ld_en),
    .out_data  (bus.w_ld_idx)
  );

  lat_pipe #(.DEPTH(PIPE), .WIDTH(TAG_W)) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (run_en),
    .in_data   ({ch_q, row_q, col_q}),
    .out_valid (tag_valid),
    .out_data  (tag_data)
  );

  assign tag_ch  = tag_data[TAG_W-1 -: CH_W];
  assign tag_row = tag_data[2*POS_W-1 -: POS_W];
  assign tag_col = tag_data[POS_W-1:0];

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.ch_idx      = ch_q;
  assign bus.w_rd_en     = rd_en;
  assign bus.w_rd_addr   = rd_en ? (W_ADDR_W'(ch_q) * W_ADDR_W'(TAPS) + W_ADDR_W'(k_q)) : '0;
  assign bus.win_valid   = run_en;
  assign bus.win_row     = row_q;
  assign bus.win_col     = col_q;
  assign bus.relu_en     = relu_q;
  assign bus.quan_en     = quan_q;
  assign bus.ofm_wr_en   = tag_valid;
  assign bus.ofm_wr_addr = OFM_ADDR_W'(tag_ch) * OFM_ADDR_W'(NPIX)
                         + OFM_ADDR_W'(tag_row) * OFM_ADDR_W'(OUT_W)
                         + OFM_ADDR_W'(tag_col);
  assign bus.state       = state_q;

endmodule

// File: tb/tb_conv1_sched.sv
// Bench for conv1_sched: default build (a) and MEM_LAT=2/IF_LAT=2 build (b)
// checked every cycle against a cycle-phase model plus an address scoreboard.
module tb_conv1_sched;
  import lenet_pkg::*;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [2:0]  ch;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        ld_en;
    logic [4:0]  ld_idx;
    logic        win;
    logic [4:0]  row;
    logic [4:0]  col;
    logic        relu;
    logic        quan;
    logic        wr_en;
    logic [12:0] wr_addr;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic start, cfg_relu, cfg_quan;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  conv1_sched_if bus_a ();
  conv1_sched_if bus_b ();

  assign bus_a.start = start;  assign bus_a.cfg_relu = cfg_relu;  assign bus_a.cfg_quan = cfg_quan;
  assign bus_b.start = start;  assign bus_b.cfg_relu = cfg_relu;  assign bus_b.cfg_quan = cfg_quan;

  conv1_sched dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
  conv1_sched #(.MEM_LAT(2), .IF_LAT(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int ml_of(input int d);  return (d == 0) ? 1 : 2;  endfunction
  function automatic int pp_of(input int d);  return (d == 0) ? 3 : 4;  endfunction
  function automatic int per_of(input int d); return 25 + ml_of(d) + 784 + pp_of(d); endfunction
  function automatic int last_of(input int d); return 1 + 6 * per_of(d); endfunction

  // Expected outputs t cycles after start was accepted (t<1: idle).
  function automatic obs_t model_out(input int t, input int d);
    obs_t e;
    int ch, ph, p, q;
    e = '0;
    if (t >= 1) begin
      e.busy = 1'b1;
      if (t == last_of(d)) begin
        e.done = 1'b1;
        e.ch   = 3'd5;
      end else begin
        ch = (t - 1) / per_of(d);
        ph = (t - 1) % per_of(d);
        e.ch = 3'(ch);
        if (ph < 25) begin
          e.rd_en = 1'b1;  e.rd_addr = 8'(ch * 25 + ph);
        end
        if (ph >= ml_of(d) && ph < ml_of(d) + 25) begin
          e.ld_en = 1'b1;  e.ld_idx = 5'(ph - ml_of(d));
        end
        p = ph - 25 - ml_of(d);
        if (p >= 0 && p < 784) begin
          e.win = 1'b1;  e.row = 5'(p / 28);  e.col = 5'(p % 28);
        end
        q = p - pp_of(d);
        if (q >= 0 && q < 784) begin
          e.wr_en = 1'b1;  e.wr_addr = 13'(ch * 784 + q);
        end
      end
    end
    return e;
  endfunction

  obs_t obs [2];
  assign obs[0] = {bus_a.busy, bus_a.done, bus_a.ch_idx, bus_a.w_rd_en, bus_a.w_rd_addr,
                   bus_a.w_ld_en, bus_a.w_ld_idx, bus_a.win_valid, bus_a.win_row, bus_a.win_col,
                   bus_a.relu_en, bus_a.quan_en, bus_a.ofm_wr_en, bus_a.ofm_wr_addr};
  assign obs[1] = {bus_b.busy, bus_b.done, bus_b.ch_idx, bus_b.w_rd_en, bus_b.w_rd_addr,
                   bus_b.w_ld_en, bus_b.w_ld_idx, bus_b.win_valid, bus_b.win_row, bus_b.win_col,
                   bus_b.relu_en, bus_b.quan_en, bus_b.ofm_wr_en, bus_b.ofm_wr_addr};

  // ---------------- model ----------------
  int   mt [2] = '{-1, -1};
  logic mrelu [2];
  logic mquan [2];
  logic [12:0] exp_q [$];
  logic [12:0] exp_q_b [$];

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mt[d] = -1;  mrelu[d] = 1'b0;  mquan[d] = 1'b0;
      end else if (mt[d] < 0) begin
        if (start) begin
          mt[d] = 1;  mrelu[d] = cfg_relu;  mquan[d] = cfg_quan;
          if (d == 0) begin
            exp_q.delete();
            for (int a = 0; a < 4704; a++) exp_q.push_back(13'(a));
          end else begin
            exp_q_b.delete();
            for (int a = 0; a < 4704; a++) exp_q_b.push_back(13'(a));
          end
        end
      end else if (mt[d] == last_of(d)) begin
        mt[d] = -1;
        chk((d == 0) ? "a.writes_left" : "b.writes_left",
            (d == 0) ? exp_q.size() : exp_q_b.size(), 0);
      end else begin
        mt[d]++;
      end
    end
  end

  // ---------------- compare ----------------
  int   last_win [2] = '{-1000, -1000};
  int   s_a = -1;
  int   ev [2][5] = '{'{-1, -1, -1, -1, -1}, '{-1, -1, -1, -1, -1}};
  logic [12:0] sb_exp;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      obs_t e, a;
      string nm;
      nm = (d == 0) ? "a" : "b";
      e = model_out(mt[d], d);
      e.relu = mrelu[d];
      e.quan = mquan[d];
      a = obs[d];
      chk({nm, ".busy"},    a.busy,    e.busy);
      chk({nm, ".done"},    a.done,    e.done);
      chk({nm, ".ch_idx"},  a.ch,      e.ch);
      chk({nm, ".rd_en"},   a.rd_en,   e.rd_en);
      chk({nm, ".rd_addr"}, a.rd_addr, e.rd_addr);
      chk({nm, ".ld_en"},   a.ld_en,   e.ld_en);
      chk({nm, ".ld_idx"},  a.ld_idx,  e.ld_idx);
      chk({nm, ".win"},     a.win,     e.win);
      chk({nm, ".row"},     a.row,     e.row);
      chk({nm, ".col"},     a.col,     e.col);
      chk({nm, ".relu"},    a.relu,    e.relu);
      chk({nm, ".quan"},    a.quan,    e.quan);
      chk({nm, ".wr_en"},   a.wr_en,   e.wr_en);
      chk({nm, ".wr_addr"}, a.wr_addr, e.wr_addr);
      if (a.wr_en) begin
        if (d == 0) begin
          if (exp_q.size() == 0) chk("a.sb_extra_write", 1, 0);
          else begin sb_exp = exp_q.pop_front(); chk("a.sb_addr", a.wr_addr, sb_exp); end
        end else begin
          if (exp_q_b.size() == 0) chk("b.sb_extra_write", 1, 0);
          else begin sb_exp = exp_q_b.pop_front(); chk("b.sb_addr", a.wr_addr, sb_exp); end
        end
      end
      if (a.ld_en) chk({nm, ".ld_while_inflight"}, int'(cyc - last_win[d] > pp_of(d)), 1);
      if (a.win) last_win[d] = cyc;
      if (s_a >= 0) begin
        if (a.rd_en && ev[d][0] < 0) ev[d][0] = cyc - s_a;
        if (a.ld_en && ev[d][1] < 0) ev[d][1] = cyc - s_a;
        if (a.win   && ev[d][2] < 0) ev[d][2] = cyc - s_a;
        if (a.wr_en && ev[d][3] < 0) ev[d][3] = cyc - s_a;
        if (a.done  && ev[d][4] < 0) ev[d][4] = cyc - s_a;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    bit fin;
    rst = 1'b1;  start = 1'b0;  cfg_relu = 1'b0;  cfg_quan = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);
    chk("rst.state_a", int'(bus_a.state), int'(S_IDLE));
    chk("rst.busy_a", bus_a.busy, 0);
    chk("rst.wr_addr_a", bus_a.ofm_wr_addr, 0);

    // Run A: relu=1 quan=0, with ignored start pulses and cfg toggles mid-run.
    start = 1'b1;  cfg_relu = 1'b1;  cfg_quan = 1'b0;  s_a = cyc;
    tick(1);    start = 1'b0;
    tick(99);   start = 1'b1;                        // cycle 100
    tick(1);    start = 1'b0;
    tick(199);  cfg_relu = 1'b0;  cfg_quan = 1'b1;   // cycle 300
    tick(1700); start = 1'b1;                        // cycle 2000
    tick(1);    start = 1'b0;
    tick(999);  cfg_relu = 1'b1;  cfg_quan = 1'b0;   // cycle 3000
    tick(1870); start = 1'b1;  cfg_relu = 1'b0;  cfg_quan = 1'b1;  // held through DONE
    tick(30);   start = 1'b0;                        // cycle 4900

    // Run B on dut_a began at cycle 4880; abort it 500 cycles in.
    tick(480);
    rst = 1'b1;
    #1;
    chk("abort.busy_a",  bus_a.busy, 0);
    chk("abort.win_a",   bus_a.win_valid, 0);
    chk("abort.wr_en_a", bus_a.ofm_wr_en, 0);
    chk("abort.quan_a",  bus_a.quan_en, 0);
    chk("abort.row_a",   bus_a.win_row, 0);
    tick(2);
    rst = 1'b0;
    tick(5);

    // Run C: fresh start replays from address 0.
    start = 1'b1;  cfg_relu = 1'b1;  cfg_quan = 1'b1;
    tick(1);
    start = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 6000 && !fin; i++) begin
      tick(1);
      if (mt[0] < 0 && mt[1] < 0) fin = 1'b1;
    end
    if (!fin) chk("run_c_timeout", 1, 0);
    tick(3);

    // First-run timing landmarks, relative to the start-accept cycle.
    chk("a.first_rd",   ev[0][0], 1);
    chk("a.first_ld",   ev[0][1], 2);
    chk("a.first_win",  ev[0][2], 27);
    chk("a.first_wr",   ev[0][3], 30);
    chk("a.done_cycle", ev[0][4], 4879);
    chk("b.first_rd",   ev[1][0], 1);
    chk("b.first_ld",   ev[1][1], 3);
    chk("b.first_win",  ev[1][2], 28);
    chk("b.first_wr",   ev[1][3], 32);
    chk("b.done_cycle", ev[1][4], 4891);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
